// File: rtl/ei_dotmac_n_pipe.sv
// N-lane dot-product MAC: registered operands, MUL_LAT product stages, registered reduction,
// then a frame accumulator with signed/unsigned mode, optional saturation and sticky overflow.
module ei_dotmac_n_pipe #(
  parameter int unsigned N        = 10,
  parameter int unsigned DW       = 8,
  parameter int unsigned ACCW     = 32,
  parameter int unsigned MUL_LAT  = 3,
  parameter int unsigned SATURATE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            valid_in,
  input  logic            first_in,
  input  logic            last_in,
  input  logic            signed_in,
  input  logic [N*DW-1:0] a_vec,
  input  logic [N*DW-1:0] b_vec,
  output logic [ACCW-1:0] acc_out,
  output logic            valid_out,
  output logic            done_out,
  output logic            ovf_out
);

  localparam int unsigned PW = 2 * DW;
  localparam int unsigned SW = PW + $clog2(N);

  // Operand capture; tags are qualified by valid so idle beats carry no framing.
  logic [N*DW-1:0] a_q, b_q;
  logic            v0_q, f0_q, l0_q, s0_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      v0_q <= 1'b0;
      f0_q <= 1'b0;
      l0_q <= 1'b0;
      s0_q <= 1'b0;
    end else if (en) begin
      a_q  <= a_vec;
      b_q  <= b_vec;
      v0_q <= valid_in;
      f0_q <= valid_in & first_in;
      l0_q <= valid_in & last_in;
      s0_q <= valid_in & signed_in;
    end
  end

  logic [N-1:0][PW-1:0] prod_d;

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic                 sa, sb;
    logic signed [PW-1:0] ea, eb;
    assign sa = s0_q & a_q[i*DW+DW-1];
    assign sb = s0_q & b_q[i*DW+DW-1];
    assign ea = {{(PW-DW){sa}}, a_q[i*DW +: DW]};
    assign eb = {{(PW-DW){sb}}, b_q[i*DW +: DW]};
    // Low PW bits of the extended product are exact in both modes.
    assign prod_d[i] = ea * eb;
  end

  logic [MUL_LAT-1:0][N-1:0][PW-1:0] prod_q;
  logic [MUL_LAT-1:0]                vp_q, fp_q, lp_q, sp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      vp_q   <= '0;
      fp_q   <= '0;
      lp_q   <= '0;
      sp_q   <= '0;
    end else if (en) begin
      prod_q[0] <= prod_d;
      vp_q[0]   <= v0_q;
      fp_q[0]   <= f0_q;
      lp_q[0]   <= l0_q;
      sp_q[0]   <= s0_q;
      for (int unsigned j = 1; j < MUL_LAT; j++) begin
        prod_q[j] <= prod_q[j-1];
        vp_q[j]   <= vp_q[j-1];
        fp_q[j]   <= fp_q[j-1];
        lp_q[j]   <= lp_q[j-1];
        sp_q[j]   <= sp_q[j-1];
      end
    end
  end

  logic [SW-1:0] sum_d;

  always_comb begin
    sum_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum_d = sum_d + {{(SW-PW){sp_q[MUL_LAT-1] & prod_q[MUL_LAT-1][i][PW-1]}},
                       prod_q[MUL_LAT-1][i]};
    end
  end

  logic [SW-1:0] sum_q;
  logic          vs_q, fs_q, ls_q, ss_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      vs_q  <= 1'b0;
      fs_q  <= 1'b0;
      ls_q  <= 1'b0;
      ss_q  <= 1'b0;
    end else if (en) begin
      sum_q <= sum_d;
      vs_q  <= vp_q[MUL_LAT-1];
      fs_q  <= fp_q[MUL_LAT-1];
      ls_q  <= lp_q[MUL_LAT-1];
      ss_q  <= sp_q[MUL_LAT-1];
    end
  end

  logic [ACCW-1:0] acc_q;
  logic            valid_q, done_q, ovf_q;
  logic [ACCW:0]   sum_x, base_x, raw;
  logic            ovf_now;
  logic [ACCW-1:0] sat_v, acc_d;

  // One guard bit above ACCW exposes both unsigned carry and signed overflow.
  always_comb begin
    sum_x   = {{(ACCW+1-SW){ss_q & sum_q[SW-1]}}, sum_q};
    base_x  = fs_q ? '0 : {ss_q & acc_q[ACCW-1], acc_q};
    raw     = base_x + sum_x;
    ovf_now = ss_q ? (raw[ACCW] ^ raw[ACCW-1]) : raw[ACCW];
    if (!ss_q) begin
      sat_v = '1;
    end else if (raw[ACCW]) begin
      sat_v = {1'b1, {(ACCW-1){1'b0}}};
    end else begin
      sat_v = {1'b0, {(ACCW-1){1'b1}}};
    end
    acc_d = ((SATURATE != 0) && ovf_now) ? sat_v : raw[ACCW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (en) begin
      valid_q <= vs_q;
      done_q  <= vs_q & ls_q;
      if (vs_q) begin
        acc_q <= acc_d;
        ovf_q <= fs_q ? ovf_now : (ovf_q | ovf_now);
      end
    end
  end

  assign acc_out   = acc_q;
  assign valid_out = valid_q;
  assign done_out  = done_q;
  assign ovf_out   = ovf_q;

endmodule

// File: tb/tb_ei_dotmac_n_pipe.sv
// Bench for ei_dotmac_n_pipe: a 32-bit wrap instance plus 20-bit saturating and wrapping
// instances, all fed the same beats and compared every cycle against an arithmetic frame model.
module tb_ei_dotmac_n_pipe;

  localparam int N  = 10;
  localparam int DW = 8;
  localparam int LAT = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b1;
  logic            valid_in = 1'b0, first_in = 1'b0, last_in = 1'b0, signed_in = 1'b0;
  logic [N*DW-1:0] a_vec = '0, b_vec = '0;
  logic [31:0]     acc0;
  logic [19:0]     acc1, acc2;
  logic [2:0]      vo, dn, of;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ei_dotmac_n_pipe u_dut (
    .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .first_in(first_in),
    .last_in(last_in), .signed_in(signed_in), .a_vec(a_vec), .b_vec(b_vec),
    .acc_out(acc0), .valid_out(vo[0]), .done_out(dn[0]), .ovf_out(of[0])
  );

  ei_dotmac_n_pipe #(.ACCW(20), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .first_in(first_in),
    .last_in(last_in), .signed_in(signed_in), .a_vec(a_vec), .b_vec(b_vec),
    .acc_out(acc1), .valid_out(vo[1]), .done_out(dn[1]), .ovf_out(of[1])
  );

  ei_dotmac_n_pipe #(.ACCW(20), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .first_in(first_in),
    .last_in(last_in), .signed_in(signed_in), .a_vec(a_vec), .b_vec(b_vec),
    .acc_out(acc2), .valid_out(vo[2]), .done_out(dn[2]), .ovf_out(of[2])
  );

  typedef struct packed {
    logic             v;
    logic             d;
    logic [2:0][31:0] acc;
    logic [2:0]       ovf;
  } exp_t;

  exp_t       pipe_q[$];
  exp_t       cur = '0;
  longint     macc[3];
  logic [2:0] movf = '0;

  function automatic int cfg_w(int c);
    return (c == 0) ? 32 : 20;
  endfunction

  function automatic longint dot();
    longint s = 0;
    for (int i = 0; i < N; i++) begin
      logic [7:0] a, b;
      a = a_vec[i*DW +: DW];
      b = b_vec[i*DW +: DW];
      if (signed_in) s += longint'($signed(a)) * longint'($signed(b));
      else           s += longint'(a) * longint'(b);
    end
    return s;
  endfunction

  // Frame semantics applied at issue time; the queue only supplies the fixed latency.
  task automatic model_edge();
    exp_t e;
    if (rst) begin
      pipe_q.delete();
      cur  = '0;
      movf = '0;
      for (int c = 0; c < 3; c++) macc[c] = 0;
      return;
    end
    if (!en) return;
    e   = '0;
    e.v = valid_in;
    e.d = valid_in & last_in;
    if (valid_in) begin
      for (int c = 0; c < 3; c++) begin
        longint w2, half, base, raw, lo, hi;
        logic   o;
        w2   = longint'(1) << cfg_w(c);
        half = w2 >> 1;
        base = first_in ? 0 : ((signed_in && macc[c] >= half) ? macc[c] - w2 : macc[c]);
        raw  = base + dot();
        lo   = signed_in ? -half : 0;
        hi   = signed_in ? half - 1 : w2 - 1;
        o    = (raw < lo) || (raw > hi);
        if (o && c == 1) raw = (raw < lo) ? lo : hi;
        macc[c] = raw & (w2 - 1);
        movf[c] = first_in ? o : (movf[c] | o);
        e.acc[c] = macc[c][31:0];
        e.ovf[c] = movf[c];
      end
    end
    pipe_q.push_back(e);
    if (pipe_q.size() > LAT) begin
      e = pipe_q.pop_front();
      cur.v = e.v;
      cur.d = e.d;
      if (e.v) begin
        cur.acc = e.acc;
        cur.ovf = e.ovf;
      end
    end
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 3; c++) begin
      logic [31:0] a;
      a = (c == 0) ? acc0 : ((c == 1) ? {12'h0, acc1} : {12'h0, acc2});
      chk($sformatf("valid[%0d]", c), 64'(vo[c]), 64'(cur.v));
      chk($sformatf("done[%0d]", c), 64'(dn[c]), 64'(cur.d));
      chk($sformatf("acc[%0d]", c), 64'(a), 64'(cur.acc[c]));
      chk($sformatf("ovf[%0d]", c), 64'(of[c]), 64'(cur.ovf[c]));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(int n);
    repeat (n) cyc();
  endtask

  task automatic lanes(logic [7:0] a, logic [7:0] b);
    for (int i = 0; i < N; i++) begin
      a_vec[i*DW +: DW] = a;
      b_vec[i*DW +: DW] = b;
    end
  endtask

  task automatic beat(logic f, logic l, logic s);
    valid_in  = 1'b1;
    first_in  = f;
    last_in   = l;
    signed_in = s;
    cyc();
    valid_in = 1'b0;
    first_in = 1'b0;
    last_in  = 1'b0;
  endtask

  initial begin
    // Reset state
    idle(2);
    chk("rst_acc", 64'(acc0), 64'd0);
    chk("rst_valid", 64'(vo), 64'd0);
    rst = 1'b0;

    // Unsigned full-scale one-beat frame
    lanes(8'd255, 8'd255);
    beat(1'b1, 1'b1, 1'b0);
    idle(4);
    chk("t1_early_valid", 64'(vo[0]), 64'd0);
    idle(1);
    chk("t1_acc", 64'(acc0), 64'd650250);
    chk("t1_done", 64'(dn[0]), 64'd1);
    chk("t1_ovf", 64'(of[0]), 64'd0);

    // Signed extreme operands
    lanes(8'h80, 8'h7f);
    beat(1'b1, 1'b1, 1'b1);
    idle(5);
    chk("t2_acc", 64'(acc0), 64'hFFFD8500);
    chk("t2_done", 64'(dn[0]), 64'd1);

    // Three-beat frame, then a new frame
    lanes(8'd1, 8'd2);
    beat(1'b1, 1'b0, 1'b0);
    lanes(8'd3, 8'd3);
    beat(1'b0, 1'b0, 1'b0);
    lanes(8'd0, 8'd3);
    beat(1'b0, 1'b1, 1'b0);
    idle(3);
    chk("t3_acc1", 64'(acc0), 64'd20);
    chk("t3_done1", 64'(dn[0]), 64'd0);
    idle(1);
    chk("t3_acc2", 64'(acc0), 64'd110);
    idle(1);
    chk("t3_acc3", 64'(acc0), 64'd110);
    chk("t3_done3", 64'(dn[0]), 64'd1);
    lanes(8'd1, 8'd1);
    beat(1'b1, 1'b1, 1'b0);
    idle(5);
    chk("t3_next", 64'(acc0), 64'd10);

    // Two-cycle stall in flight
    lanes(8'd255, 8'd255);
    beat(1'b1, 1'b1, 1'b0);
    idle(1);
    en = 1'b0;
    idle(2);
    chk("t4_stall_acc", 64'(acc0), 64'd10);
    en = 1'b1;
    idle(3);
    chk("t4_not_yet", 64'(vo[0]), 64'd0);
    idle(1);
    chk("t4_acc", 64'(acc0), 64'd650250);
    chk("t4_valid", 64'(vo[0]), 64'd1);
    idle(1);
    chk("t4_pulse", 64'(vo[0]), 64'd0);

    // 20-bit overflow: saturate vs wrap, then a fresh frame clears the flag
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b0);
    idle(5);
    chk("t5_sat_acc", 64'(acc1), 64'd1048575);
    chk("t5_sat_ovf", 64'(of[1]), 64'd1);
    chk("t5_wrap_acc", 64'(acc2), 64'd251924);
    chk("t5_wrap_ovf", 64'(of[2]), 64'd1);
    lanes(8'd1, 8'd1);
    beat(1'b1, 1'b1, 1'b0);
    idle(5);
    chk("t5_clear_sat", 64'(of[1]), 64'd0);
    chk("t5_clear_wrap", 64'(of[2]), 64'd0);

    // Reset with a beat in flight
    lanes(8'd255, 8'd255);
    beat(1'b1, 1'b1, 1'b0);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      idle(1);
      chk("t6_valid", 64'(vo[0]), 64'd0);
      chk("t6_acc", 64'(acc0), 64'd0);
    end

    // Random traffic with stalls, mode changes and rare resets
    for (int k = 0; k < 400; k++) begin
      en        = ($urandom_range(0, 7) != 0);
      rst       = ($urandom_range(0, 149) == 0);
      valid_in  = ($urandom_range(0, 3) != 0);
      first_in  = ($urandom_range(0, 3) == 0);
      last_in   = ($urandom_range(0, 3) == 0);
      signed_in = $urandom_range(0, 1) == 1;
      for (int i = 0; i < N; i++) begin
        a_vec[i*DW +: DW] = 8'($urandom);
        b_vec[i*DW +: DW] = 8'($urandom);
      end
      cyc();
    end
    rst      = 1'b0;
    en       = 1'b1;
    valid_in = 1'b0;
    idle(LAT + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
